// File: rtl/coef_mem_arbiter.sv
// coef_mem_arbiter: shares one single-port coefficient BRAM (1-cycle read
// latency) between a burst loader (reads), a burst saver (writes) and a
// single-beat host port. A granted burst runs to completion without
// preemption. Read bursts end with one DRAIN cycle that carries the final
// read beat back to the requester.
//
// Build option: define COEF_ARB_RR_EN for round-robin arbitration among the
// three requesters (cyclic order loader -> saver -> host -> loader, starting
// at saver after reset). Without it, arbitration is fixed priority
// saver > loader > host and no pointer state exists.
module coef_mem_arbiter #(
  parameter int N = 16,
  parameter int A = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_req,
  input  logic         sv_req,
  input  logic         hs_req,
  input  logic [A-1:0] ld_addr,
  input  logic [A-1:0] sv_addr,
  input  logic [A-1:0] hs_addr,
  input  logic [7:0]   ld_len,
  input  logic [7:0]   sv_len,
  output logic         ld_gnt,
  output logic         sv_gnt,
  output logic         hs_gnt,
  output logic         ld_vld,
  output logic [N-1:0] ld_data,
  output logic         sv_pop,
  input  logic [N-1:0] sv_data,
  input  logic         hs_we,
  input  logic [N-1:0] hs_wdata,
  output logic         hs_rvld,
  output logic [N-1:0] hs_rdata,
  output logic [A-1:0] mem_addr,
  output logic [7:0]   mem_we,
  output logic [N-1:0] mem_din,
  input  logic [N-1:0] mem_dout,
  output logic         busy,
  output logic [1:0]   owner
);

  // Owner codes double as requester identifiers in the arbiter.
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_LD   = 2'd1;
  localparam logic [1:0] OWN_SV   = 2'd2;
  localparam logic [1:0] OWN_HS   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t         state;
  logic [7:0]     beat_idx;    // index of the beat currently on the bus
  logic [7:0]     last_idx;    // index of the final beat (len-1, 0 -> 255)
  logic           hs_we_q;     // host access direction, latched at grant
  logic [N-1:0]   hs_din_q;    // host write data, latched at grant

  logic [1:0]     win;         // requester that would win in IDLE
  logic [A-1:0]   start_addr;
  logic [7:0]     start_last;

`ifdef COEF_ARB_RR_EN
  logic [1:0] rr_ptr;          // requester checked first in the next IDLE
  logic [3:0] req_vec;
  logic [1:0] cand0, cand1, cand2;

  // Cyclic successor in the order loader -> saver -> host -> loader.
  function automatic logic [1:0] next_req(input logic [1:0] c);
    return (c == OWN_HS) ? OWN_LD : c + 2'd1;
  endfunction

  // Round-robin pick: scan the three requesters starting at the pointer.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    win     = OWN_NONE;
    req_vec = {hs_req, sv_req, ld_req, 1'b0};
    cand0   = rr_ptr;
    cand1   = next_req(cand0);
    cand2   = next_req(cand1);
    if (req_vec[cand0])      win = cand0;
    else if (req_vec[cand1]) win = cand1;
    else if (req_vec[cand2]) win = cand2;
  end
`else
  // Fixed priority pick: saver first, then loader, then host.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    win = OWN_NONE;
    if (sv_req)      win = OWN_SV;
    else if (ld_req) win = OWN_LD;
    else if (hs_req) win = OWN_HS;
  end
`endif

  // Start address and final beat index of the winning request.
  always_comb begin
    start_addr = '0;
    start_last = 8'd0;
    case (win)
      OWN_LD: begin
        start_addr = ld_addr;
        start_last = ld_len - 8'd1;
      end
      OWN_SV: begin
        start_addr = sv_addr;
        start_last = sv_len - 8'd1;
      end
      OWN_HS: begin
        start_addr = hs_addr;
        start_last = 8'd0;
      end
      default: ;
    endcase
  end

  // Arbitration FSM; all bus controls are registered so a beat's address,
  // enable and pop line appear together in the cycle after each edge.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= OWN_NONE;
      busy     <= 1'b0;
      beat_idx <= 8'd0;
      last_idx <= 8'd0;
      hs_we_q  <= 1'b0;
      hs_din_q <= '0;
      mem_addr <= '0;
      mem_we   <= 8'h00;
      sv_pop   <= 1'b0;
      ld_gnt   <= 1'b0;
      sv_gnt   <= 1'b0;
      hs_gnt   <= 1'b0;
      ld_vld   <= 1'b0;
      hs_rvld  <= 1'b0;
`ifdef COEF_ARB_RR_EN
      rr_ptr   <= OWN_SV;
`endif
    end else begin
      ld_gnt  <= 1'b0;
      sv_gnt  <= 1'b0;
      hs_gnt  <= 1'b0;
      // Read data returns one cycle after each read beat on the bus.
      ld_vld  <= (state == BURST) && (owner == OWN_LD);
      hs_rvld <= (state == BURST) && (owner == OWN_HS) && !hs_we_q;

      case (state)
        IDLE: begin
          if (win != OWN_NONE) begin
            state    <= BURST;
            owner    <= win;
            busy     <= 1'b1;
            beat_idx <= 8'd0;
            last_idx <= start_last;
            mem_addr <= start_addr;
            hs_we_q  <= hs_we;
            hs_din_q <= hs_wdata;
            ld_gnt   <= (win == OWN_LD);
            sv_gnt   <= (win == OWN_SV);
            hs_gnt   <= (win == OWN_HS);
            sv_pop   <= (win == OWN_SV);
            mem_we   <= ((win == OWN_SV) || ((win == OWN_HS) && hs_we)) ? 8'hFF : 8'h00;
          end
        end

        BURST: begin
          if (beat_idx == last_idx) begin
            mem_we <= 8'h00;
            sv_pop <= 1'b0;
`ifdef COEF_ARB_RR_EN
            rr_ptr <= next_req(owner);
`endif
            // A read still has its final beat in flight; writes are done.
            if (mem_we == 8'h00) begin
              state <= DRAIN;
            end else begin
              state <= IDLE;
              owner <= OWN_NONE;
              busy  <= 1'b0;
            end
          end else begin
            beat_idx <= beat_idx + 8'd1;
            mem_addr <= mem_addr + {{(A-1){1'b0}}, 1'b1};
          end
        end

        DRAIN: begin
          state <= IDLE;
          owner <= OWN_NONE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          owner <= OWN_NONE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Saver data streams straight through while it is being popped; host
  // write data comes from the grant-time latch. Both are zero otherwise.
  assign mem_din  = sv_pop ? sv_data : ((mem_we != 8'h00) ? hs_din_q : '0);

  // Returned read data is only driven while its valid strobe is high.
  assign ld_data  = ld_vld  ? mem_dout : '0;
  assign hs_rdata = hs_rvld ? mem_dout : '0;

endmodule

// File: tb/tb_coef_mem_arbiter.sv
// Directed bench for coef_mem_arbiter with a 1-cycle-latency BRAM model.
// Inputs change away from the rising edge; outputs are sampled on the
// falling edge. Define COEF_ARB_RR_EN on both files to exercise round robin.
module tb_coef_mem_arbiter;

  localparam int N = 16;
  localparam int A = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ld_req = 1'b0, sv_req = 1'b0, hs_req = 1'b0;
  logic [A-1:0] ld_addr = '0, sv_addr = '0, hs_addr = '0;
  logic [7:0]   ld_len = 8'd0, sv_len = 8'd0;
  logic         ld_gnt, sv_gnt, hs_gnt;
  logic         ld_vld;
  logic [N-1:0] ld_data;
  logic         sv_pop;
  logic [N-1:0] sv_data = '0;
  logic         hs_we = 1'b0;
  logic [N-1:0] hs_wdata = '0;
  logic         hs_rvld;
  logic [N-1:0] hs_rdata;
  logic [A-1:0] mem_addr;
  logic [7:0]   mem_we;
  logic [N-1:0] mem_din;
  logic [N-1:0] mem_dout;
  logic         busy;
  logic [1:0]   owner;

  int n_checks = 0;
  int n_fails  = 0;

  // BRAM model: preloaded with mem[k] = k, one-cycle read latency.
  logic [N-1:0] mem [1 << A];
  logic [N-1:0] mem_q = '0;
  bit           mem_ready = 1'b0;
  int           wr_cnt = 0;

  assign mem_dout = mem_q;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int k = 0; k < (1 << A); k++) mem[k] <= N'(k);
      mem_ready <= 1'b1;
    end else begin
      if (mem_we != 8'h00) begin
        mem[mem_addr] <= mem_din;
        wr_cnt <= wr_cnt + 1;
      end
      mem_q <= mem[mem_addr];
    end
  end

  always #5 clk = ~clk;

  coef_mem_arbiter #(.N(N), .A(A)) dut (
    .clk(clk), .rst(rst),
    .ld_req(ld_req), .sv_req(sv_req), .hs_req(hs_req),
    .ld_addr(ld_addr), .sv_addr(sv_addr), .hs_addr(hs_addr),
    .ld_len(ld_len), .sv_len(sv_len),
    .ld_gnt(ld_gnt), .sv_gnt(sv_gnt), .hs_gnt(hs_gnt),
    .ld_vld(ld_vld), .ld_data(ld_data),
    .sv_pop(sv_pop), .sv_data(sv_data),
    .hs_we(hs_we), .hs_wdata(hs_wdata), .hs_rvld(hs_rvld), .hs_rdata(hs_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
    .busy(busy), .owner(owner)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ld_req = 1'b0; sv_req = 1'b0; hs_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 600) begin n_fails++; $display("FAIL %s_idle_timeout: busy still %b after %0d cycles", name, busy, n); end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({ld_gnt, sv_gnt, hs_gnt, ld_vld, sv_pop, hs_rvld} !== 6'b0) begin
      n_fails++; $display("FAIL reset_strobes: got %b expected 000000", {ld_gnt, sv_gnt, hs_gnt, ld_vld, sv_pop, hs_rvld});
    end
    n_checks++;
    if (busy !== 1'b0 || owner !== 2'd0) begin
      n_fails++; $display("FAIL reset_busy_owner: got busy=%b owner=%0d expected 0/0", busy, owner);
    end
    n_checks++;
    if (mem_we !== 8'h00 || mem_addr !== '0 || mem_din !== '0) begin
      n_fails++; $display("FAIL reset_mem_bus: got we=%h addr=%h din=%h expected 0", mem_we, mem_addr, mem_din);
    end
    n_checks++;
    if (ld_data !== '0 || hs_rdata !== '0) begin
      n_fails++; $display("FAIL reset_data: got ld=%h hs=%h expected 0", ld_data, hs_rdata);
    end
    rst = 1'b0;
  endtask

  // Loader burst from addr with length code len (0 means 256 beats).
  task automatic test_load(input logic [A-1:0] addr, input logic [7:0] len, input string name);
    int beats;
    int busy_cnt = 0, vld_cnt = 0, addr_err = 0, data_err = 0, gnt_err = 0;
    logic [A-1:0] ea;
    beats = (len == 8'd0) ? 256 : int'(len);
    @(negedge clk);
    ld_req = 1'b1; ld_addr = addr; ld_len = len;
    @(negedge clk);
    n_checks++;
    if (ld_gnt !== 1'b1 || owner !== 2'd1) begin
      n_fails++; $display("FAIL %s_grant: got gnt=%b owner=%0d expected 1/1", name, ld_gnt, owner);
    end
    for (int i = 0; i <= beats; i++) begin
      if (i > 0 && ld_gnt !== 1'b0) gnt_err++;
      if (i == 0) ld_req = 1'b0;
      if (busy === 1'b1) busy_cnt++;
      ea = addr + A'(i);
      if (i < beats && (mem_addr !== ea || mem_we !== 8'h00)) addr_err++;
      if (ld_vld === 1'b1) begin
        ea = addr + A'(vld_cnt);
        if (i == 0 || ld_data !== N'(ea)) data_err++;
        vld_cnt++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (busy !== 1'b0 || owner !== 2'd0 || ld_vld !== 1'b0) begin
      n_fails++; $display("FAIL %s_end_idle: got busy=%b owner=%0d vld=%b expected 0/0/0", name, busy, owner, ld_vld);
    end
    n_checks++;
    if (busy_cnt != beats + 1) begin n_fails++; $display("FAIL %s_busy_cycles: got %0d expected %0d", name, busy_cnt, beats + 1); end
    n_checks++;
    if (vld_cnt != beats) begin n_fails++; $display("FAIL %s_vld_count: got %0d expected %0d", name, vld_cnt, beats); end
    n_checks++;
    if (addr_err != 0) begin n_fails++; $display("FAIL %s_addr_seq: got %0d bad beats expected 0", name, addr_err); end
    n_checks++;
    if (data_err != 0) begin n_fails++; $display("FAIL %s_data_seq: got %0d bad beats expected 0", name, data_err); end
    n_checks++;
    if (gnt_err != 0) begin n_fails++; $display("FAIL %s_gnt_pulse: got %0d extra grant cycles expected 0", name, gnt_err); end
    @(negedge clk);
  endtask

  task automatic test_host();
    @(negedge clk);
    hs_req = 1'b1; hs_we = 1'b1; hs_addr = 10'h020; hs_wdata = 16'h1234;
    @(negedge clk);
    n_checks++;
    if (hs_gnt !== 1'b1 || owner !== 2'd3 || mem_we !== 8'hFF || mem_addr !== 10'h020 || mem_din !== 16'h1234) begin
      n_fails++; $display("FAIL host_write_beat: got gnt=%b own=%0d we=%h addr=%h din=%h expected 1/3/ff/020/1234",
                          hs_gnt, owner, mem_we, mem_addr, mem_din);
    end
    hs_req = 1'b0; hs_we = 1'b0; hs_wdata = 16'h0000;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || mem_we !== 8'h00) begin
      n_fails++; $display("FAIL host_write_end: got busy=%b we=%h expected 0/00", busy, mem_we);
    end
    hs_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if (hs_gnt !== 1'b1 || mem_we !== 8'h00 || mem_addr !== 10'h020 || hs_rvld !== 1'b0) begin
      n_fails++; $display("FAIL host_read_beat: got gnt=%b we=%h addr=%h rvld=%b expected 1/00/020/0", hs_gnt, mem_we, mem_addr, hs_rvld);
    end
    hs_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (hs_rvld !== 1'b1 || hs_rdata !== 16'h1234 || busy !== 1'b1) begin
      n_fails++; $display("FAIL host_read_data: got rvld=%b data=%h busy=%b expected 1/1234/1", hs_rvld, hs_rdata, busy);
    end
    @(negedge clk);
    n_checks++;
    if (hs_rvld !== 1'b0 || busy !== 1'b0 || owner !== 2'd0) begin
      n_fails++; $display("FAIL host_read_end: got rvld=%b busy=%b owner=%0d expected 0/0/0", hs_rvld, busy, owner);
    end
  endtask

  task automatic test_priority();
    int beat_err = 0;
    do_reset();
    sv_req = 1'b1; ld_req = 1'b1;
    sv_addr = 10'h100; sv_len = 8'd3; ld_addr = 10'h200; ld_len = 8'd2;
    sv_data = 16'hA000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin
        n_checks++;
        if (sv_gnt !== 1'b1 || owner !== 2'd2) begin
          n_fails++; $display("FAIL prio_sv_first: got sv_gnt=%b owner=%0d expected 1/2", sv_gnt, owner);
        end
        sv_req = 1'b0;
      end
      if (ld_gnt !== 1'b0 || sv_pop !== 1'b1 || mem_we !== 8'hFF ||
          mem_addr !== 10'h100 + A'(i) || mem_din !== 16'hA000 + N'(i)) beat_err++;
      @(posedge clk);
      #1 sv_data = 16'hA000 + N'(i + 1);
    end
    n_checks++;
    if (beat_err != 0) begin n_fails++; $display("FAIL prio_sv_beats: got %0d bad beats expected 0", beat_err); end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || sv_pop !== 1'b0 || ld_gnt !== 1'b0) begin
      n_fails++; $display("FAIL prio_gap_idle: got busy=%b pop=%b ld_gnt=%b expected 0/0/0", busy, sv_pop, ld_gnt);
    end
    @(negedge clk);
    n_checks++;
    if (ld_gnt !== 1'b1 || owner !== 2'd1) begin
      n_fails++; $display("FAIL prio_ld_second: got ld_gnt=%b owner=%0d expected 1/1", ld_gnt, owner);
    end
    ld_req = 1'b0;
    n_checks++;
    if (mem[10'h100] !== 16'hA000 || mem[10'h101] !== 16'hA001 || mem[10'h102] !== 16'hA002 || mem[10'h103] !== 16'h0103) begin
      n_fails++; $display("FAIL prio_sv_contents: got %h %h %h %h expected a000 a001 a002 0103",
                          mem[10'h100], mem[10'h101], mem[10'h102], mem[10'h103]);
    end
    wait_idle("prio");
  endtask

  // Three-way contention; requesters hold until granted.
  task automatic test_contention();
    logic [1:0] exp_order [3];
    logic [1:0] got_order [3];
    int got = 0;
    int n = 0;
`ifdef COEF_ARB_RR_EN
    exp_order = '{2'd2, 2'd3, 2'd1};
`else
    exp_order = '{2'd2, 2'd1, 2'd3};
`endif
    do_reset();
    sv_req = 1'b1; ld_req = 1'b1; hs_req = 1'b1;
    sv_addr = 10'h300; sv_len = 8'd1; sv_data = 16'h5A5A;
    ld_addr = 10'h040; ld_len = 8'd1;
    hs_addr = 10'h050; hs_we = 1'b0;
    while (got < 3 && n < 60) begin
      @(negedge clk);
      n++;
      if (sv_gnt === 1'b1 || ld_gnt === 1'b1 || hs_gnt === 1'b1) begin
        got_order[got] = sv_gnt ? 2'd2 : (ld_gnt ? 2'd1 : 2'd3);
        if (sv_gnt) sv_req = 1'b0;
        if (ld_gnt) ld_req = 1'b0;
        if (hs_gnt) hs_req = 1'b0;
        got++;
      end
    end
    sv_req = 1'b0; ld_req = 1'b0; hs_req = 1'b0;
    n_checks++;
    if (got != 3) begin n_fails++; $display("FAIL contention_grants: got %0d grants expected 3", got); end
    for (int i = 0; i < got; i++) begin
      n_checks++;
      if (got_order[i] !== exp_order[i]) begin
        n_fails++; $display("FAIL contention_order_%0d: got owner %0d expected %0d", i, got_order[i], exp_order[i]);
      end
    end
    wait_idle("contention");
  endtask

  task automatic test_reset_midburst();
    int wr_snap;
    sv_req = 1'b1; sv_addr = 10'h180; sv_len = 8'd8; sv_data = 16'hB000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (i == 0) sv_req = 1'b0;
      @(posedge clk);
      #1 sv_data = 16'hB000 + N'(i + 1);
    end
    @(negedge clk);
    n_checks++;
    if (mem_addr !== 10'h182 || sv_pop !== 1'b1 || mem_din !== 16'hB002) begin
      n_fails++; $display("FAIL rst_mid_beat2: got addr=%h pop=%b din=%h expected 182/1/b002", mem_addr, sv_pop, mem_din);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (mem_we !== 8'h00 || sv_pop !== 1'b0 || busy !== 1'b0 || owner !== 2'd0) begin
      n_fails++; $display("FAIL rst_mid_async: got we=%h pop=%b busy=%b owner=%0d expected 00/0/0/0", mem_we, sv_pop, busy, owner);
    end
    n_checks++;
    if (mem_addr !== '0 || mem_din !== '0) begin
      n_fails++; $display("FAIL rst_mid_bus: got addr=%h din=%h expected 0/0", mem_addr, mem_din);
    end
    wr_snap = wr_cnt;
    repeat (3) @(negedge clk);
    n_checks++;
    if (wr_cnt != wr_snap) begin n_fails++; $display("FAIL rst_mid_no_writes: got %0d writes expected 0", wr_cnt - wr_snap); end
    n_checks++;
    if (mem[10'h180] !== 16'hB000 || mem[10'h181] !== 16'hB001 || mem[10'h182] !== 16'h0182) begin
      n_fails++; $display("FAIL rst_mid_contents: got %h %h %h expected b000 b001 0182", mem[10'h180], mem[10'h181], mem[10'h182]);
    end
    // Request presented as reset releases is granted on the very next edge.
    rst = 1'b0;
    ld_req = 1'b1; ld_addr = 10'h010; ld_len = 8'd1;
    @(negedge clk);
    n_checks++;
    if (ld_gnt !== 1'b1) begin n_fails++; $display("FAIL rst_first_req: got ld_gnt=%b expected 1", ld_gnt); end
    ld_req = 1'b0;
    wait_idle("rst_first");
  endtask

  initial begin
    test_reset();
    test_load(10'h010, 8'd4, "load_basic");
    test_load(10'h3FE, 8'd4, "load_wrap");
    test_load(10'h380, 8'd0, "load_256");
    test_host();
    test_priority();
    test_contention();
    test_reset_midburst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/coef_mem_arbiter.md
COEF_MEM_ARBITER -- requirements
Module: coef_mem_arbiter

Interface
REQ-001 SHALL have parameter N, default 16, meaning data width in bits (fixed-point word).
REQ-002 SHALL have parameter A, default 10, meaning coefficient-memory address width.
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports ld_req/sv_req/hs_req  input  1 each  requests from loader/saver/host.
REQ-006 SHALL have ports ld_addr/sv_addr/hs_addr  input  A each  start address.
REQ-007 SHALL have ports ld_len/sv_len  input  8 each  burst length; 0 means 256 beats.
REQ-008 SHALL have ports ld_gnt/sv_gnt/hs_gnt  output  1 each  one-cycle grant pulse.
REQ-009 SHALL have ports ld_vld output 1, ld_data output N  read beat returned to loader.
REQ-010 SHALL have ports sv_pop output 1, sv_data input N  saver write data, consumed when sv_pop=1.
REQ-011 SHALL have ports hs_we input 1, hs_wdata input N, hs_rvld output 1, hs_rdata output N  single-beat host access.
REQ-012 SHALL have ports mem_addr output A, mem_we output 8, mem_din output N, mem_dout input N  single-port BRAM, 1-cycle read latency.
REQ-013 SHALL have ports busy output 1, owner output 2  (0 none, 1 loader, 2 saver, 3 host).

Function
REQ-014 FSM states: IDLE, BURST, DRAIN.
REQ-015 IDLE: any req sampled high -> winner chosen, its gnt pulsed for one cycle, address/length latched, owner set, state -> BURST on next edge.
REQ-016 Fixed priority: saver > loader > host.
REQ-017 BURST: one memory access per cycle, mem_addr = latched start + beat index, mod 2^A (wrap, no error).
REQ-018 Loader burst: mem_we=8'h00; ld_vld high exactly one cycle after each read beat, ld_data=mem_dout.
REQ-019 Saver burst: mem_we=8'hFF, mem_din=sv_data, sv_pop=1 on every beat.
REQ-020 Host: exactly 1 beat; write if hs_we latched 1, else read with hs_rvld/hs_rdata one cycle later.
REQ-021 Burst SHALL NOT be preempted; req deassertion mid-burst is ignored; burst runs to full length.
REQ-022 After last beat: read owner -> DRAIN (1 cycle, final vld) -> IDLE; write owner -> IDLE directly.
REQ-023 Requests arriving during BURST/DRAIN are held by requester and evaluated only in IDLE; min 1 IDLE cycle between bursts.
REQ-024 busy=1 in BURST and DRAIN; owner valid in BURST/DRAIN, 0 in IDLE.
REQ-025 Beat counter 8 bits; len=0 -> 256 beats, address increment still wraps at 2^A.

Reset
REQ-026 rst asserted (any time, incl. mid-burst): state IDLE, burst aborted, all gnt/vld/pop/rvld=0, mem_we=8'h00, mem_addr=0, mem_din=0, busy=0, owner=0, ld_data/hs_rdata=0.
REQ-027 First request evaluated on first rising edge after rst deasserts.

Configuration
REQ-028 Macro COEF_ARB_RR_EN defined: round-robin priority among the three requesters; pointer advances to the requester after the one granted, on burst completion.
REQ-029 COEF_ARB_RR_EN undefined: fixed priority per REQ-016; no pointer state.

Verification
REQ-030 Loader only, ld_addr=0x010, ld_len=4, mem holds k at addr k -> ld_gnt 1 cycle, reads 0x010..0x013, ld_vld 4 cycles, data 0x10..0x13, DRAIN then IDLE.
REQ-031 sv_req and ld_req same cycle, fixed priority -> sv_gnt first, 3-beat write completes, then ld_gnt; with COEF_ARB_RR_EN, three-way contention grants saver, host, loader in rotation.
REQ-032 Wrap: ld_addr=2^A-2, ld_len=4 -> addresses 2^A-2, 2^A-1, 0, 1.
REQ-033 ld_len=0 -> 256 read beats, 256 ld_vld pulses, busy high for 257 cycles.
REQ-034 rst asserted at beat 2 of 8-beat save -> same cycle mem_we=8'h00, sv_pop=0, busy=0, owner=0; no further writes.
REQ-035 Host write 0x1234 to 0x020, then host read 0x020 -> hs_rvld one cycle after read beat, hs_rdata=0x1234.
